// File: rtl/rat_io_pkg.sv
// Shared port map, debounce state encoding and pending-bit layout for the RAT MCU I/O responder.
package rat_io_pkg;

  localparam logic [7:0] PID_SW    = 8'h20;
  localparam logic [7:0] PID_STAT  = 8'h21;
  localparam logic [7:0] PID_MASK  = 8'h22;
  localparam logic [7:0] PID_TCNT  = 8'h23;
  localparam logic [7:0] PID_LEDS  = 8'h40;
  localparam logic [7:0] PID_SSEG  = 8'h81;
  localparam logic [7:0] PID_ACK   = 8'hF0;
  localparam logic [7:0] PID_IMASK = 8'hF1;
  localparam logic [7:0] PID_TRLD  = 8'hF2;

  localparam int PEND_BTN = 0;
  localparam int PEND_TMR = 1;

  typedef enum logic [1:0] {
    LOW,
    WAIT_HI,
    HIGH,
    WAIT_LO
  } deb_state_t;

endpackage

// File: rtl/rat_io_responder_btn_debounce.sv
// Button synchroniser plus qualify-by-stability FSM; btn_evt pulses on the edge that enters HIGH.
module btn_debounce
  import rat_io_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_evt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic btn_s1, btn_s2;
  deb_state_t state, next_state;
  logic [CW-1:0] cnt;
  logic cnt_done;

  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOW;
    end else begin
      state <= next_state;
    end
  end

  // The sample that moves us into a wait state is already the first stable one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (next_state == WAIT_HI || next_state == WAIT_LO) begin
      cnt <= (state == next_state) ? cnt + CW'(1) : CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      LOW:     if (btn_s2) next_state = WAIT_HI;
      WAIT_HI: if (!btn_s2) next_state = LOW;
               else if (cnt_done) next_state = HIGH;
      HIGH:    if (!btn_s2) next_state = WAIT_LO;
      WAIT_LO: if (btn_s2) next_state = HIGH;
               else if (cnt_done) next_state = LOW;
      default: next_state = LOW;
    endcase
  end

  always_comb begin
    btn_evt = (state == WAIT_HI) && (next_state == HIGH);
  end

endmodule

// File: rtl/rat_io_responder.sv
// RAT MCU port-bus responder: output registers, input mux, debounced button interrupt.
// Optional periodic timer interrupt is built when RAT_IO_TIMER_EN is defined.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int DEB_CYCLES   = 500000,
  parameter int TMR_PRESCALE = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT_CU,
  input  logic [7:0] SWITCHES,
  input  logic       BTN,
  output logic [7:0] LEDS,
  output logic [7:0] SSEG_VAL
);

  logic [7:0] sw_s1, sw_s2;
  logic [7:0] leds_q, sseg_q;
  logic [1:0] pend, mask;
  logic       int_q;
  logic       btn_evt;
  logic       tmr_expire;
  logic [7:0] tcnt_rd;
  logic [1:0] ack_bits, set_bits;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk     (CLK),
    .rst     (RESET),
    .btn     (BTN),
    .btn_evt (btn_evt)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sw_s1 <= 8'h00;
      sw_s2 <= 8'h00;
    end else begin
      sw_s1 <= SWITCHES;
      sw_s2 <= sw_s1;
    end
  end

`ifdef RAT_IO_TIMER_EN
  localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TMR_PRESCALE - 1);

  logic [7:0]    reload, tcnt;
  logic [PW-1:0] presc;

  // Expiry fires on the tick that would take the count from 1 to 0; it reloads instead.
  assign tmr_expire = (reload != 8'h00) && (presc == PRESC_MAX) && (tcnt == 8'h01);
  assign tcnt_rd    = tcnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      reload <= 8'h00;
      tcnt   <= 8'h00;
      presc  <= '0;
    end else if (IO_STRB && PORT_ID == PID_TRLD) begin
      reload <= OUT_PORT;
      tcnt   <= OUT_PORT;
      presc  <= '0;
    end else if (reload != 8'h00) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        tcnt  <= (tcnt == 8'h01) ? reload : tcnt - 8'h01;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end
`else
  assign tmr_expire = 1'b0;
  assign tcnt_rd    = 8'h00;
`endif

  assign ack_bits = (IO_STRB && PORT_ID == PID_ACK) ? OUT_PORT[1:0] : 2'b00;

  always_comb begin
    set_bits           = 2'b00;
    set_bits[PEND_BTN] = btn_evt;
    set_bits[PEND_TMR] = tmr_expire;
  end

  // A new set in the same cycle as its ack wins, so no event is lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      leds_q <= 8'h00;
      sseg_q <= 8'h00;
      mask   <= 2'b00;
      pend   <= 2'b00;
      int_q  <= 1'b0;
    end else begin
      int_q <= |(pend & mask);
      pend  <= (pend & ~ack_bits) | set_bits;
      if (IO_STRB) begin
        case (PORT_ID)
          PID_LEDS:  leds_q <= OUT_PORT;
          PID_SSEG:  sseg_q <= OUT_PORT;
          PID_IMASK: mask   <= OUT_PORT[1:0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    case (PORT_ID)
      PID_SW:   IN_PORT = sw_s2;
      PID_STAT: IN_PORT = {6'b0, pend};
      PID_MASK: IN_PORT = {6'b0, mask};
      PID_TCNT: IN_PORT = tcnt_rd;
      default:  IN_PORT = 8'h00;
    endcase
  end

  assign LEDS     = leds_q;
  assign SSEG_VAL = sseg_q;
  assign INT_CU   = int_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// Randomised bench for rat_io_responder against a run-length / arithmetic reference model.
module tb_rat_io_responder;

  localparam int DEB = 16;
  localparam int PRE = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] PORT_ID = 8'h00;
  logic [7:0] OUT_PORT = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] SWITCHES = 8'h00;
  logic       BTN = 1'b0;
  logic [7:0] IN_PORT;
  logic       INT_CU;
  logic [7:0] LEDS;
  logic [7:0] SSEG_VAL;

  always #5 CLK = ~CLK;

  rat_io_responder #(.DEB_CYCLES(DEB), .TMR_PRESCALE(PRE)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .IO_STRB  (IO_STRB),
    .IN_PORT  (IN_PORT),
    .INT_CU   (INT_CU),
    .SWITCHES (SWITCHES),
    .BTN      (BTN),
    .LEDS     (LEDS),
    .SSEG_VAL (SSEG_VAL)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_leds, m_sseg, m_sw1, m_sw2;
  logic [1:0] m_pend, m_mask;
  logic       m_int, m_b1, m_b2, m_level;
  int         m_ones, m_zeros;
`ifdef RAT_IO_TIMER_EN
  logic [7:0] m_reload;
  int         m_t;
`endif

  logic [7:0] pid_list [10] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40,
                                8'h81, 8'hF0, 8'hF1, 8'hF2, 8'h77};

  task automatic model_reset();
    m_leds = 8'h00; m_sseg = 8'h00; m_sw1 = 8'h00; m_sw2 = 8'h00;
    m_pend = 2'b00; m_mask = 2'b00; m_int = 1'b0;
    m_b1 = 1'b0; m_b2 = 1'b0; m_level = 1'b0; m_ones = 0; m_zeros = 0;
`ifdef RAT_IO_TIMER_EN
    m_reload = 8'h00; m_t = 0;
`endif
  endtask

  // Button qualifies once its synchronised value has held for DEB consecutive samples.
  task automatic model_edge();
    logic use_b, evt, texp;
    logic [1:0] ack;
    use_b = m_b2; m_b2 = m_b1; m_b1 = BTN;
    m_sw2 = m_sw1; m_sw1 = SWITCHES;
    evt = 1'b0; texp = 1'b0;
    if (use_b) begin m_ones++; m_zeros = 0; end
    else begin m_zeros++; m_ones = 0; end
    if (!m_level && m_ones >= DEB) begin m_level = 1'b1; evt = 1'b1; end
    else if (m_level && m_zeros >= DEB) m_level = 1'b0;
`ifdef RAT_IO_TIMER_EN
    if (m_reload != 8'h00) begin
      m_t++;
      if (m_t == int'(m_reload) * PRE) begin texp = 1'b1; m_t = 0; end
    end
`endif
    ack = (IO_STRB && PORT_ID == 8'hF0) ? OUT_PORT[1:0] : 2'b00;
    m_int  = |(m_pend & m_mask);
    m_pend = (m_pend & ~ack) | {texp, evt};
    if (IO_STRB) begin
      case (PORT_ID)
        8'h40: m_leds = OUT_PORT;
        8'h81: m_sseg = OUT_PORT;
        8'hF1: m_mask = OUT_PORT[1:0];
`ifdef RAT_IO_TIMER_EN
        8'hF2: begin m_reload = OUT_PORT; m_t = 0; end
`endif
        default: ;
      endcase
    end
  endtask

  function automatic logic [7:0] exp_in(input logic [7:0] pid);
    case (pid)
      8'h20: return m_sw2;
      8'h21: return {6'b0, m_pend};
      8'h22: return {6'b0, m_mask};
`ifdef RAT_IO_TIMER_EN
      8'h23: return (m_reload == 8'h00) ? 8'h00 : m_reload - 8'(m_t / PRE);
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    if (RESET) model_reset();
    else model_edge();
    @(negedge CLK);
  endtask

  task automatic write_port(input logic [7:0] pid, input logic [7:0] data);
    PORT_ID = pid; OUT_PORT = data; IO_STRB = 1'b1;
    step();
    IO_STRB = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    model_reset();
    repeat (3) step();
    n_checks++; if (LEDS !== 8'h00) $display("[TB] FAIL reset_leds got %h want 00", LEDS); else n_pass++;
    n_checks++; if (SSEG_VAL !== 8'h00) $display("[TB] FAIL reset_sseg got %h want 00", SSEG_VAL); else n_pass++;
    n_checks++; if (INT_CU !== 1'b0) $display("[TB] FAIL reset_int got %b want 0", INT_CU); else n_pass++;
    PORT_ID = 8'h21; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL reset_pend got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = 8'h22; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL reset_mask got %h want 00", IN_PORT); else n_pass++;
    RESET = 1'b0;
    step();
  endtask

  task automatic test_writes();
    logic [7:0] pid;
    write_port(8'h40, 8'hA5);
    n_checks++; if (LEDS !== 8'hA5) $display("[TB] FAIL leds_write got %h want A5", LEDS); else n_pass++;
    PORT_ID = 8'h40; OUT_PORT = 8'h3C; IO_STRB = 1'b0;
    step();
    n_checks++; if (LEDS !== 8'hA5) $display("[TB] FAIL leds_nostrb got %h want A5", LEDS); else n_pass++;
    for (int i = 0; i < 30; i++) begin
      pid = pid_list[$urandom_range(0, 9)];
      if (pid == 8'hF1) pid = 8'h81;
      PORT_ID = pid; OUT_PORT = 8'($urandom); IO_STRB = 1'($urandom);
      step();
      IO_STRB = 1'b0;
      n_checks++; if (LEDS !== m_leds) $display("[TB] FAIL rand_leds got %h want %h", LEDS, m_leds); else n_pass++;
      n_checks++; if (SSEG_VAL !== m_sseg) $display("[TB] FAIL rand_sseg got %h want %h", SSEG_VAL, m_sseg); else n_pass++;
    end
  endtask

  task automatic test_reads();
    logic [7:0] sw;
    PORT_ID = 8'h20;
    for (int i = 0; i < 10; i++) begin
      sw = (i == 0) ? 8'h5A : 8'($urandom);
      SWITCHES = sw;
      step(); step();
      n_checks++; if (IN_PORT !== sw) $display("[TB] FAIL sw_sync got %h want %h", IN_PORT, sw); else n_pass++;
    end
    PORT_ID = 8'h77; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL unmapped_read got %h want 00", IN_PORT); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      SWITCHES = 8'($urandom);
      PORT_ID = pid_list[$urandom_range(0, 9)];
      step();
      n_checks++; if (IN_PORT !== exp_in(PORT_ID)) $display("[TB] FAIL read_mux pid %h got %h want %h", PORT_ID, IN_PORT, exp_in(PORT_ID)); else n_pass++;
    end
  endtask

  task automatic test_debounce();
    write_port(8'hF1, 8'h01);
    PORT_ID = 8'h21;
    for (int i = 0; i < 8; i++) begin
      BTN = (i % 2 == 0);
      repeat (5) begin
        step();
        n_checks++; if (IN_PORT !== exp_in(8'h21)) $display("[TB] FAIL bounce_pend got %h want %h", IN_PORT, exp_in(8'h21)); else n_pass++;
      end
    end
    BTN = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      n_checks++; if (INT_CU !== m_int) $display("[TB] FAIL hold_int cyc %0d got %b want %b", i, INT_CU, m_int); else n_pass++;
    end
    n_checks++; if (IN_PORT !== 8'h01) $display("[TB] FAIL deb_pend got %h want 01", IN_PORT); else n_pass++;
    n_checks++; if (INT_CU !== 1'b1) $display("[TB] FAIL deb_int got %b want 1", INT_CU); else n_pass++;
  endtask

  task automatic test_ack();
    logic found;
    write_port(8'hF0, 8'h01);
    PORT_ID = 8'h21; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL ack_pend got %h want 00", IN_PORT); else n_pass++;
    step();
    n_checks++; if (INT_CU !== 1'b0) $display("[TB] FAIL ack_int got %b want 0", INT_CU); else n_pass++;
    BTN = 1'b0;
    repeat (DEB + 4) step();
    BTN = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (!m_level && m_b2 && m_ones == DEB - 1) begin
        PORT_ID = 8'hF0; OUT_PORT = 8'h01; IO_STRB = 1'b1; found = 1'b1;
      end
      step();
      IO_STRB = 1'b0; PORT_ID = 8'h21;
    end
    if (!found) begin
      n_checks++;
      $display("[TB] FAIL ack_race_setup no event within bound");
    end
    #1;
    n_checks++; if (IN_PORT !== 8'h01) $display("[TB] FAIL set_wins got %h want 01", IN_PORT); else n_pass++;
  endtask

  task automatic test_mask();
    step(); step();
    write_port(8'hF1, 8'h00);
    PORT_ID = 8'h21;
    step();
    n_checks++; if (INT_CU !== 1'b0) $display("[TB] FAIL masked_int got %b want 0", INT_CU); else n_pass++;
    n_checks++; if (IN_PORT !== 8'h01) $display("[TB] FAIL masked_pend got %h want 01", IN_PORT); else n_pass++;
    write_port(8'hF1, 8'h01);
    step();
    n_checks++; if (INT_CU !== 1'b1) $display("[TB] FAIL unmask_int got %b want 1", INT_CU); else n_pass++;
  endtask

  task automatic test_reset_debounce();
    BTN = 1'b1;
    repeat (30) step();
    RESET = 1'b1; model_reset();
    #1;
    n_checks++; if (INT_CU !== 1'b0) $display("[TB] FAIL rst_int got %b want 0", INT_CU); else n_pass++;
    step();
    RESET = 1'b0;
    write_port(8'hF1, 8'h01);
    PORT_ID = 8'h21;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++; if (IN_PORT !== exp_in(8'h21)) $display("[TB] FAIL requal_pend cyc %0d got %h want %h", i, IN_PORT, exp_in(8'h21)); else n_pass++;
    end
    n_checks++; if (IN_PORT !== 8'h01) $display("[TB] FAIL requal_event got %h want 01", IN_PORT); else n_pass++;
  endtask

  task automatic test_timer();
`ifdef RAT_IO_TIMER_EN
    write_port(8'hF0, 8'h03);
    write_port(8'hF1, 8'h02);
    write_port(8'hF2, 8'h03);
    for (int i = 0; i < 40; i++) begin
      PORT_ID = (i % 2 == 0) ? 8'h23 : 8'h21;
      if (m_pend[1] && i % 12 == 5) begin
        PORT_ID = 8'hF0; OUT_PORT = 8'h02; IO_STRB = 1'b1;
      end
      step();
      IO_STRB = 1'b0;
      n_checks++; if (INT_CU !== m_int) $display("[TB] FAIL tmr_int cyc %0d got %b want %b", i, INT_CU, m_int); else n_pass++;
      n_checks++; if (IN_PORT !== exp_in(PORT_ID)) $display("[TB] FAIL tmr_read pid %h got %h want %h", PORT_ID, IN_PORT, exp_in(PORT_ID)); else n_pass++;
    end
    RESET = 1'b1; model_reset();
    PORT_ID = 8'h23; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL tmr_rst_cnt got %h want 00", IN_PORT); else n_pass++;
    n_checks++; if ({LEDS, SSEG_VAL, INT_CU} !== 17'h0) $display("[TB] FAIL tmr_rst_outs got %h want 0", {LEDS, SSEG_VAL, INT_CU}); else n_pass++;
    step();
    RESET = 1'b0;
`else
    write_port(8'hF1, 8'h02);
    write_port(8'hF2, 8'h03);
    PORT_ID = 8'h23; #1;
    n_checks++; if (IN_PORT !== 8'h00) $display("[TB] FAIL notmr_cnt got %h want 00", IN_PORT); else n_pass++;
    PORT_ID = 8'h21;
    repeat (20) step();
    n_checks++; if (IN_PORT[1] !== 1'b0) $display("[TB] FAIL notmr_pend got %b want 0", IN_PORT[1]); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int run_left;
    run_left = 0;
    for (int i = 0; i < 400; i++) begin
      if (run_left == 0) begin
        BTN = 1'($urandom);
        run_left = $urandom_range(1, 30);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) SWITCHES = 8'($urandom);
      PORT_ID = pid_list[$urandom_range(0, 9)];
      OUT_PORT = 8'($urandom);
      IO_STRB = ($urandom_range(0, 3) == 0);
      step();
      n_checks++; if (IN_PORT !== exp_in(PORT_ID)) $display("[TB] FAIL rnd_in pid %h got %h want %h", PORT_ID, IN_PORT, exp_in(PORT_ID)); else n_pass++;
      IO_STRB = 1'b0;
      n_checks++; if (INT_CU !== m_int) $display("[TB] FAIL rnd_int cyc %0d got %b want %b", i, INT_CU, m_int); else n_pass++;
      n_checks++; if (LEDS !== m_leds) $display("[TB] FAIL rnd_leds got %h want %h", LEDS, m_leds); else n_pass++;
      n_checks++; if (SSEG_VAL !== m_sseg) $display("[TB] FAIL rnd_sseg got %h want %h", SSEG_VAL, m_sseg); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_writes();
    test_reads();
    test_debounce();
    test_ack();
    test_mask();
    test_reset_debounce();
    test_timer();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
